// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit with a req/ack data-memory port,
// load alignment and extension, misalignment detection and a bus timeout.
module mem_access_stage #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_out_M,
    input  logic [31:0]       wd_dm_M,
    input  logic              we_dm_M,
    input  logic              dm2reg_M,
    input  logic [1:0]        mem_size_M,
    input  logic              mem_unsigned_M,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    output logic [31:0]       rd_dm,
    output logic              stall_M,
    output logic              misalign,
    output logic              bus_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic          uns_q;

    logic [1:0]    lane;
    logic          any_op;
    logic          access;
    logic [3:0]    be_n;
    logic [31:0]   wdata_n;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_v;

    assign lane   = alu_out_M[1:0];
    assign any_op = we_dm_M | dm2reg_M;
    assign misalign = any_op &
        (((mem_size_M == 2'b01) & lane[0]) |
         (mem_size_M[1] & (lane != 2'b00)));
    assign access = any_op & ~misalign;

    always_comb begin
        stall_M = 1'b0;
        unique case (state)
            IDLE:    stall_M = access;
            REQ:     stall_M = 1'b1;
            default: stall_M = 1'b0;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = wd_dm_M;
        unique case (1'b1)
            (mem_size_M == 2'b00): begin
                be_n    = 4'b0001 << lane;
                wdata_n = {4{wd_dm_M[7:0]}};
            end
            (mem_size_M == 2'b01): begin
                be_n    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wd_dm_M[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the offset latched at request time
    assign byte_sel = dm_rdata[{lane_q, 3'b000} +: 8];
    assign half_sel = dm_rdata[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        load_v = dm_rdata;
        unique case (1'b1)
            (size_q == 2'b00):
                load_v = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            (size_q == 2'b01):
                load_v = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tmo      <= '0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_be    <= '0;
            dm_wdata <= '0;
            rd_dm    <= '0;
            bus_err  <= 1'b0;
            size_q   <= '0;
            lane_q   <= '0;
            uns_q    <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (access) begin
                        state    <= REQ;
                        tmo      <= '0;
                        dm_req   <= 1'b1;
                        dm_we    <= we_dm_M;
                        dm_addr  <= alu_out_M[ADDR_W+1:2];
                        dm_be    <= be_n;
                        dm_wdata <= wdata_n;
                        size_q   <= mem_size_M;
                        lane_q   <= lane;
                        uns_q    <= mem_unsigned_M;
                    end
                end
                REQ: begin
                    tmo <= tmo + 1'b1;
                    if (dm_ack) begin
                        state  <= DONE;
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        rd_dm  <= dm_we ? '0 : load_v;
                    end else if (tmo == TMO_LAST) begin
                        state   <= DONE;
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        bus_err <= 1'b1;
                        rd_dm   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tmo   <= '0;
                end
            endcase
        end
    end
endmodule
